c3_result_collector: RTL and testbench
======================================

// Module: c3_result_collector
// PURPOSE
//  Downstream stage of the C3 convolution sub-module. Captures the KERNEL_NUM inner-product
//  results produced after each kernel_calculating_pulse, applies optional ReLU, tags each with
//  its feature-map address (kernel*MAP_SIZE + position), and buffers them in a FIFO drained to
//  the C3 output-map RAM over a valid/ready write port. Tracks anchor position and flags frame end.
// PARAMETERS
//  KERNEL_NUM  16    results captured per pulse (one per kernel, kernel_bias_idx 0..KERNEL_NUM-1)
//  IP_LATENCY  3     cycles from sampled pulse to kernel-0 result on inner_product_out
//  MAP_SIZE    100   output positions per feature map (10x10)
//  ADDR_W      11    write-address width; must hold KERNEL_NUM*MAP_SIZE-1
//  FIFO_DEPTH  16    entries in write FIFO (power of 2)
// PORTS
//  clk                     in   1       clock
//  rst_n                   in   1       reset; synchronous, active-high (1 = reset)
//  kernel_calculating_pulse in  1       start of a KERNEL_NUM-result burst
//  inner_product_out       in   16      signed Q-format result, one kernel per cycle
//  wr_ready                in   1       output RAM accepts entry
//  wr_valid                out  1       FIFO head valid
//  wr_addr                 out  ADDR_W  feature-map address of head entry
//  wr_data                 out  16      data of head entry
//  frame_done              out  1       1-cycle pulse: last entry of a frame pushed
//  overlap_err             out  1       sticky: pulse arrived while not IDLE
//  ovf_err                 out  1       sticky: push attempted while FIFO full
// BEHAVIOUR
//  - Reset: one clock clk; reset rst_n is synchronous and active-high. All outputs 0; FSM IDLE;
//    pos=0, kcnt=0, FIFO emptied, sticky errors cleared. Reset mid-burst discards partial burst.
//  - FSM: IDLE -(pulse)-> WAIT; WAIT counts IP_LATENCY-1 cycles -> CAPTURE; CAPTURE runs exactly
//    KERNEL_NUM cycles (kcnt 0..KERNEL_NUM-1) -> IDLE. IP_LATENCY=1 goes straight to CAPTURE.
//  - Timing: pulse sampled high at cycle t -> kernel k sampled at t+IP_LATENCY+k, pushed same edge.
//  - Push entry {addr = kcnt*MAP_SIZE + pos, data}; addr computed with counters, no multiplier
//    on the critical path (running base += MAP_SIZE per kcnt).
//  - After kcnt=KERNEL_NUM-1 push: pos increments; pos==MAP_SIZE-1 wraps to 0 and frame_done
//    pulses in the cycle after that final push.
//  - Pulse while in WAIT/CAPTURE: ignored, overlap_err set; current burst completes unchanged.
//  - FIFO: pop when wr_valid & wr_ready; wr_valid = !empty; head data registered (stable while
//    wr_valid & !wr_ready). Simultaneous push+pop when full: push accepted (no drop). Push when
//    full without pop: entry dropped, ovf_err set, pos/kcnt still advance.
//  - Empty: wr_valid=0, wr_addr/wr_data hold last value.
// CONFIGURATION
//  C3_RELU_EN defined: data = inner_product_out[15] ? 16'h0000 : inner_product_out.
//  C3_RELU_EN undefined: data = inner_product_out passed unmodified (signed).
// TESTING
//  1 pulse, IP_LATENCY=3, inputs 16'h0010+k, wr_ready=1 -> 16 writes addr k*100, data 0x0010+k.
//  2 C3_RELU_EN, input 16'hFF00 at k=2 -> wr_data 0x0000 at addr 200; undefined -> 0xFF00.
//  3 100 bursts back-to-back -> last write addr 1599, frame_done 1 cycle, next burst addr 0.
//  4 wr_ready=0 for whole burst, FIFO_DEPTH=16 -> 16 held entries, ovf_err=0; 2nd burst -> ovf_err=1.
//  5 pulse again at CAPTURE kcnt=5 -> overlap_err=1, still exactly 16 pushes from first burst.
//  6 rst_n=1 at kcnt=8 -> wr_valid=0, errors 0, next pulse writes addr 0 with pos=0.

Source files
------------

// File: rtl/c3_result_collector.sv
// Purpose : capture KERNEL_NUM inner-product results per pulse, optional ReLU (C3_RELU_EN), tag with map address, queue for output RAM.
// Latency : pulse at edge t -> kernel k captured/pushed at edge t+IP_LATENCY+k; head visible on wr_* the cycle after the push into an empty FIFO.
// Backpressure: wr_valid/wr_ready drain; a full FIFO without a same-cycle pop drops the entry and sets sticky ovf_err.
module c3_result_collector #(
    parameter int KERNEL_NUM = 16,
    parameter int IP_LATENCY = 3,
    parameter int MAP_SIZE   = 100,
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kernel_calculating_pulse,
    input  logic [15:0]       inner_product_out,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              overlap_err,
    output logic              ovf_err
);

    localparam int KW        = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam int PW        = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
    localparam int WW        = (IP_LATENCY > 2) ? $clog2(IP_LATENCY - 1) : 1;
    localparam int WAIT_LAST = (IP_LATENCY > 1) ? IP_LATENCY - 2 : 0;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENT_W     = ADDR_W + 16;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

    state_t              state;
    logic [WW-1:0]       wcnt;
    logic [KW-1:0]       kcnt;
    logic [PW-1:0]       pos;
    logic [ADDR_W-1:0]   base;      // kcnt*MAP_SIZE, advanced by addition

    logic                push;
    logic                last_k;
    logic [ADDR_W-1:0]   push_addr;
    logic [15:0]         push_data;
    logic [ENT_W-1:0]    push_entry;

    logic [ENT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic                full;
    logic                pop;
    logic                push_ok;

    assign push      = (state == S_CAPTURE);
    assign last_k    = (kcnt == KW'(KERNEL_NUM - 1));
    assign push_addr = base + ADDR_W'(pos);

`ifdef C3_RELU_EN
    assign push_data = inner_product_out[15] ? 16'h0000 : inner_product_out;
`else
    assign push_data = inner_product_out;
`endif

    assign push_entry = {push_addr, push_data};
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = wr_valid & wr_ready;
    assign push_ok    = push & (~full | pop);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    assign count_nxt  = count + CNT_W'(push_ok) - CNT_W'(pop);

    // Burst sequencing: wait out the inner-product latency, then step through kernels and positions
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            kcnt        <= '0;
            pos         <= '0;
            base        <= '0;
            frame_done  <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (kernel_calculating_pulse && (state != S_IDLE))
                overlap_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (kernel_calculating_pulse) begin
                        wcnt  <= '0;
                        state <= (IP_LATENCY == 1) ? S_CAPTURE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == WW'(WAIT_LAST))
                        state <= S_CAPTURE;
                    else
                        wcnt <= wcnt + WW'(1);
                end
                S_CAPTURE: begin
                    if (last_k) begin
                        state <= S_IDLE;
                        kcnt  <= '0;
                        base  <= '0;
                        if (pos == PW'(MAP_SIZE - 1)) begin
                            pos        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end else begin
                        kcnt <= kcnt + KW'(1);
                        base <= base + ADDR_W'(MAP_SIZE);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers, occupancy, registered head (holds last value when empty) and overflow flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            count    <= count_nxt;
            wr_valid <= (count_nxt != '0);
            if (push && full && !pop)
                ovf_err <= 1'b1;
            if (pop && (count > CNT_W'(1)))
                {wr_addr, wr_data} <= mem[rd_ptr_nxt];
            else if (push_ok && ((count == '0) || (pop && (count == CNT_W'(1)))))
                {wr_addr, wr_data} <= push_entry;
        end
    end

endmodule

// File: tb/tb_c3_result_collector.sv
// Bench for c3_result_collector: directed table bursts, multi-cycle corner sequences,
// and randomized bursts checked every cycle against a queue-based reference model.
// Honors C3_RELU_EN for expected data.
module tb_c3_result_collector;

    localparam int L     = 3;
    localparam int K     = 16;
    localparam int MAP   = 100;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        int          burst;
        int          k;
        logic [15:0] din;
        logic [10:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kernel_calculating_pulse;
    logic [15:0] inner_product_out;
    logic        wr_ready;
    logic        wr_valid;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        overlap_err;
    logic        ovf_err;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    int   fd_cnt = 0;
    ent_t wr_log[$];
    logic [15:0] bvals [K];
    vec_t tbl [2*K];

    // reference model state
    ent_t mq[$];
    ent_t m_last = '0;
    bit   m_active = 1'b0;
    int   m_since = 0;
    int   m_pos = 0;
    bit   m_fd = 1'b0;
    bit   m_ovl = 1'b0;
    bit   m_ovf = 1'b0;

    c3_result_collector dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .kernel_calculating_pulse (kernel_calculating_pulse),
        .inner_product_out        (inner_product_out),
        .wr_ready                 (wr_ready),
        .wr_valid                 (wr_valid),
        .wr_addr                  (wr_addr),
        .wr_data                  (wr_data),
        .frame_done               (frame_done),
        .overlap_err              (overlap_err),
        .ovf_err                  (ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef C3_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] log_addr(input int i);
        if (i < wr_log.size()) return wr_log[i].addr;
        return 11'hxxx;
    endfunction

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Reference model: spec rules applied per clock edge with a bounded queue as the FIFO
    always @(posedge clk) begin
        ent_t pe;
        bit   push;
        int   kk;
        push = 1'b0;
        pe   = '0;
        if (rst_n) begin
            mq.delete();
            m_last   = '0;
            m_active = 1'b0;
            m_since  = 0;
            m_pos    = 0;
            m_fd     = 1'b0;
            m_ovl    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (m_active) begin
                if (kernel_calculating_pulse) m_ovl = 1'b1;
                m_since++;
                if (m_since >= L) begin
                    kk      = m_since - L;
                    pe.addr = 11'(kk * MAP + m_pos);
                    pe.data = relu(inner_product_out);
                    push    = 1'b1;
                    if (kk == K - 1) begin
                        m_active = 1'b0;
                        if (m_pos == MAP - 1) begin
                            m_pos = 0;
                            m_fd  = 1'b1;
                        end else begin
                            m_pos++;
                        end
                    end
                end
            end else if (kernel_calculating_pulse) begin
                m_active = 1'b1;
                m_since  = 0;
            end
            if (wr_ready && mq.size() != 0) m_last = mq.pop_front();
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(pe);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle check of every output against the model, plus handshake log
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_valid", 32'(wr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("head_addr", 32'(wr_addr), 32'(mq[0].addr));
                chk("head_data", 32'(wr_data), 32'(mq[0].data));
            end else begin
                chk("hold_addr", 32'(wr_addr), 32'(m_last.addr));
                chk("hold_data", 32'(wr_data), 32'(m_last.data));
            end
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("overlap_err", 32'(overlap_err), 32'(m_ovl));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            if (wr_valid && wr_ready) wr_log.push_back({wr_addr, wr_data});
            if (frame_done) fd_cnt++;
        end
    end

    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            kernel_calculating_pulse = 1'b0;
            inner_product_out        = 16'($urandom);
            wr_ready                 = pick_ready(rdy_mode);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        kernel_calculating_pulse = 1'b0;
        wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    // One pulse plus the data stream it expects; optional extra pulse and mid-burst reset
    task automatic run_burst(input int extra_j, input int rst_j, input int rdy_mode);
        for (int j = 0; j < L + K; j++) begin
            @(posedge clk); #1;
            kernel_calculating_pulse = (j == 0) || (j == extra_j);
            inner_product_out        = (j >= L) ? bvals[j-L] : 16'($urandom);
            wr_ready                 = pick_ready(rdy_mode);
            if (j == rst_j) begin
                rst_n = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b0;
                kernel_calculating_pulse = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] relu_neg_ff00;
        logic [15:0] relu_neg_8001;
`ifdef C3_RELU_EN
        relu_neg_ff00 = 16'h0000;
        relu_neg_8001 = 16'h0000;
`else
        relu_neg_ff00 = 16'hFF00;
        relu_neg_8001 = 16'h8001;
`endif
        // directed vector table: burst 0 plain ramp, burst 1 with negative inputs
        for (int k = 0; k < K; k++) begin
            tbl[k].burst    = 0;
            tbl[k].k        = k;
            tbl[k].din      = 16'h0010 + 16'(k);
            tbl[k].exp_addr = 11'(k * 100);
            tbl[k].exp_data = 16'h0010 + 16'(k);
            tbl[K+k].burst    = 1;
            tbl[K+k].k        = k;
            tbl[K+k].din      = 16'h0100 + 16'(k);
            tbl[K+k].exp_addr = 11'(k * 100);
            tbl[K+k].exp_data = 16'h0100 + 16'(k);
        end
        tbl[K+2].din = 16'hFF00;  tbl[K+2].exp_data = relu_neg_ff00;
        tbl[K+9].din = 16'h8001;  tbl[K+9].exp_data = relu_neg_8001;

        rst_n = 1'b1;
        kernel_calculating_pulse = 1'b0;
        inner_product_out = 16'h0000;
        wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_errors", 32'({overlap_err, ovf_err}), 0);

        // table-driven bursts
        for (int b = 0; b < 2; b++) begin
            do_reset();
            for (int i = 0; i < 2*K; i++)
                if (tbl[i].burst == b) bvals[tbl[i].k] = tbl[i].din;
            wr_log.delete();
            run_burst(-1, -1, 1);
            idle(4, 1);
            chk("tbl_count", 32'(wr_log.size()), 32'(K));
            for (int i = 0; i < 2*K; i++) begin
                if (tbl[i].burst == b) begin
                    if (tbl[i].k < wr_log.size()) begin
                        chk("tbl_addr", 32'(wr_log[tbl[i].k].addr), 32'(tbl[i].exp_addr));
                        chk("tbl_data", 32'(wr_log[tbl[i].k].data), 32'(tbl[i].exp_data));
                    end else begin
                        chk("tbl_present", 32'(wr_log.size()), 32'(tbl[i].k + 1));
                    end
                end
            end
        end

        // full frame of back-to-back bursts, wrap to position 0
        do_reset();
        wr_log.delete();
        fd_cnt = 0;
        for (int b = 0; b < MAP; b++) begin
            for (int k = 0; k < K; k++) bvals[k] = 16'($urandom);
            run_burst(-1, -1, 1);
        end
        idle(3, 1);
        chk("frame_writes", 32'(wr_log.size()), 32'(MAP * K));
        chk("frame_last_addr", 32'(log_addr(MAP * K - 1)), 1599);
        chk("frame_done_cnt", 32'(fd_cnt), 1);
        wr_log.delete();
        run_burst(-1, -1, 1);
        idle(3, 1);
        chk("wrap_first_addr", 32'(log_addr(0)), 0);

        // backpressure: fill exactly, then overflow
        do_reset();
        for (int k = 0; k < K; k++) bvals[k] = 16'h0200 + 16'(k);
        run_burst(-1, -1, 0);
        idle(2, 0);
        chk("bp_valid", 32'(wr_valid), 1);
        chk("bp_head_addr", 32'(wr_addr), 0);
        chk("bp_no_ovf", 32'(ovf_err), 0);
        run_burst(-1, -1, 0);
        idle(1, 0);
        chk("bp_ovf", 32'(ovf_err), 1);
        wr_log.delete();
        idle(40, 1);
        chk("bp_drained", 32'(wr_log.size()), 16);
        chk("bp_last_addr", 32'(log_addr(15)), 1500);

        // overlapping pulse at kcnt=5
        do_reset();
        wr_log.delete();
        run_burst(L + 5, -1, 1);
        idle(4, 1);
        chk("ovl_err", 32'(overlap_err), 1);
        chk("ovl_count", 32'(wr_log.size()), 16);
        chk("ovl_last_addr", 32'(log_addr(15)), 1500);
        wr_log.delete();
        run_burst(-1, -1, 1);
        idle(4, 1);
        chk("ovl_next_pos", 32'(log_addr(0)), 1);

        // reset mid-burst at kcnt=8 with errors pending
        do_reset();
        run_burst(L + 2, L + 8, 0);
        @(negedge clk);
        chk("mid_rst_valid", 32'(wr_valid), 0);
        chk("mid_rst_errs", 32'({overlap_err, ovf_err}), 0);
        wr_log.delete();
        run_burst(-1, -1, 1);
        idle(4, 1);
        chk("mid_rst_addr0", 32'(log_addr(0)), 0);
        chk("mid_rst_count", 32'(wr_log.size()), 16);

        // randomized bursts, gaps, backpressure and stray pulses
        do_reset();
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < K; k++) bvals[k] = 16'($urandom);
            run_burst(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, L + K - 1)) : -1, -1, 2);
            idle($urandom_range(0, 3), 2);
        end
        idle(60, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
